geodesic_stroke_buffer: RTL
===========================

// Module: geodesic_stroke_buffer
// PURPOSE
//  Upstream of the geodesic CAPTCHA renderer. Rasterises the user's mouse stroke into a
//  96x64 1-bit bitmap using a 3x3 brush. Counts unique painted pixels and serves a
//  registered per-pixel read port, which the renderer uses to colour the trail.
//  Also flags the end of each stroke so the answer checker can compare pixel counts.
// PARAMETERS
//  SCREEN_W  96  bitmap width in pixels
//  SCREEN_H  64  bitmap height in pixels
//  BRUSH_R   1   brush radius; brush is (2*BRUSH_R+1)^2 cells
//  COUNT_W   13  width of drawn_count
// PORTS
//  clock        in   1   system clock
//  reset_n      in   1   asynchronous, active-low reset
//  clear        in   1   1-cycle pulse: erase bitmap and zero the count
//  mouse_x      in   12  cursor column
//  mouse_y      in   12  cursor row
//  mouse_l      in   1   left button (level)
//  pixel_index  in   13  display read address = y*SCREEN_W + x
//  pixel_hit    out  1   bitmap bit at the pixel_index presented on the previous cycle
//  drawn_count  out  13  number of set bits, saturating
//  busy         out  1   high while clearing
//  stroke_done  out  1   1-cycle pulse on the falling edge of mouse_l
// BEHAVIOUR
//  Reset: pixel_hit=0, drawn_count=0, stroke_done=0, busy=1. FSM enters CLEAR because
//   bitmap contents are not reset. last_x/last_y are set to an invalid value (all ones).
//  FSM states and transitions:
//   IDLE  -> PAINT when mouse_l=1, mouse_x<SCREEN_W, mouse_y<SCREEN_H, and
//            (mouse_x,mouse_y) differs from (last_x,last_y). Latch the position as the brush centre.
//   PAINT -> one brush cell per cycle; cell counter k=0..8; dx=k%3-1, dy=k/3-1
//            (for BRUSH_R=1). Returns to IDLE after the last cell and updates last_x/last_y.
//   CLEAR -> sweeps addr 0..SCREEN_W*SCREEN_H-1 writing 0, one word per cycle.
//            Then goes to IDLE; busy falls in the cycle IDLE is entered.
//  Per PAINT cell:
//   - Skip cells with centre+dx or centre+dy outside the screen. No wrap-around.
//   - If the bit is 0, write 1 and increment drawn_count.
//   - If the bit is already 1, no count change.
//  drawn_count saturates at 2^COUNT_W-1.
//  Mouse moves during PAINT are ignored until IDLE. The mouse is resampled on the next IDLE cycle.
//  clear:
//   - From any state, jumps to CLEAR at addr 0 and zeroes drawn_count next cycle.
//   - Aborts PAINT.
//   - During CLEAR, restarts the sweep.
//   - Also resets last_x/last_y.
//  pixel_hit latency: 1 cycle. pixel_index >= SCREEN_W*SCREEN_H returns 0.
//   During CLEAR the read port returns the current memory contents; no stall.
//  stroke_done: registered mouse_l_q. Pulse when mouse_l_q=1 and mouse_l=0, except in CLEAR.
//   last_x/last_y are invalidated on the same edge, so a new stroke repaints freely.
//  Simultaneous events:
//   - clear beats paint.
//   - A paint write and the display read of the same address in the same cycle:
//     the read returns the old value.
// CONFIGURATION
//  STROKE_ERASE_EN defined:
//   - Extra input port erase (1 bit, right button).
//   - erase=1 with mouse_l=0 runs a PAINT pass in erase mode: set bits are written to 0
//     and drawn_count is decremented (floored at 0).
//   - mouse_l has priority when both buttons are pressed.
//   - The falling edge of erase does not pulse stroke_done.
//  STROKE_ERASE_EN undefined: no erase port; the bitmap only ever sets bits.
// STRUCTURE
//  Package geodesic_pkg: SCREEN_W, SCREEN_H, NUM_PIXELS=6144, ADDR_W=13,
//   typedef enum {IDLE, PAINT, CLEAR} stroke_state_t, and a pixel_addr_t typedef.
//  Sub-module stroke_bitmap: NUM_PIXELS x 1 memory.
//   - One write/read port for the FSM, with combinational read.
//   - One registered read port for the display.
//  The FSM, counter and edge detect stay in the top level.
// TESTING
//  1. Release reset_n -> busy=1 for 6144 cycles, then 0.
//     Then pixel_hit=0 for every index and drawn_count=0.
//  2. mouse_l=1 at (48,32), held -> drawn_count=9 after 9 PAINT cycles.
//     Index 32*96+47 reads 1; index 30*96+48 reads 0.
//  3. Paint at (0,0) -> 4 cells set (0,0),(1,0),(0,1),(1,1); drawn_count=4; no wrap to column 95.
//  4. Paint at (10,10), then move to (11,10) -> drawn_count=9+3=12.
//     Holding at (11,10) adds nothing; release -> stroke_done high exactly 1 cycle.
//  5. clear pulse mid-PAINT at cell k=4 -> drawn_count=0 next cycle, busy=1.
//     After the sweep all bits are 0. mouse_l asserted during CLEAR causes no painting.
//  6. STROKE_ERASE_EN: paint at (20,20), then erase at (21,20) -> drawn_count=9-6=3.
//     erase at (90,60) on empty area -> count stays 3.

Source files
------------

// File: rtl/geodesic_stroke_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : geodesic_pkg
// Purpose  : Shared geometry, state encoding and address helper for the
//            geodesic stroke buffer.
// Revision : 1.0
// ============================================================================
package geodesic_pkg;

    localparam int SCREEN_W   = 96;
    localparam int SCREEN_H   = 64;
    localparam int BRUSH_R    = 1;
    localparam int COUNT_W    = 13;
    localparam int COORD_W    = 12;
    localparam int NUM_PIXELS = SCREEN_W * SCREEN_H;
    localparam int ADDR_W     = 13;
    localparam int BRUSH_D    = 2 * BRUSH_R + 1;
    localparam int K_W        = $clog2(BRUSH_D);

    typedef logic [ADDR_W-1:0] pixel_addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAINT = 2'd1,
        CLEAR = 2'd2
    } stroke_state_t;

    // Row-major linear address of an on-screen (x, y).
    function automatic pixel_addr_t pixel_addr(input logic [13:0] x, input logic [13:0] y);
        return pixel_addr_t'(32'(y) * SCREEN_W + 32'(x));
    endfunction

endpackage
`default_nettype wire

// File: rtl/geodesic_stroke_buffer_bitmap.sv
`default_nettype none
// ============================================================================
// Module   : stroke_bitmap
// Purpose  : NUM_PIXELS x 1 bitmap with a combinational read/write FSM port
//            and a registered display read port.
// Revision : 1.0
// ============================================================================
module stroke_bitmap
    import geodesic_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        fsm_we,
    input  pixel_addr_t fsm_addr,
    input  logic        fsm_wdata,
    output logic        fsm_rdata,
    input  pixel_addr_t disp_index,
    output logic        disp_hit
);

    localparam pixel_addr_t c_num_pixels = pixel_addr_t'(NUM_PIXELS);

    logic r_mem [NUM_PIXELS];
    logic r_disp_hit;

    // Contents are deliberately not reset; the FSM sweeps them after reset.
    always_ff @(posedge clock) begin
        if (fsm_we && (fsm_addr < c_num_pixels)) begin
            r_mem[fsm_addr] <= fsm_wdata;
        end
    end

    assign fsm_rdata = (fsm_addr < c_num_pixels) ? r_mem[fsm_addr] : 1'b0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_disp_hit <= 1'b0;
        end else begin
            r_disp_hit <= (disp_index < c_num_pixels) ? r_mem[disp_index] : 1'b0;
        end
    end

    assign disp_hit = r_disp_hit;

endmodule
`default_nettype wire

// File: rtl/geodesic_stroke_buffer.sv
`default_nettype none
// ============================================================================
// Module   : geodesic_stroke_buffer
// Purpose  : Rasterises a mouse stroke with a square brush into a 1-bit
//            bitmap, counts painted pixels and flags stroke ends.
//            Optional erase button enabled by `define STROKE_ERASE_EN.
// Revision : 1.0
// ============================================================================
module geodesic_stroke_buffer
    import geodesic_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    input  logic [COORD_W-1:0] mouse_x,
    input  logic [COORD_W-1:0] mouse_y,
    input  logic               mouse_l,
`ifdef STROKE_ERASE_EN
    input  logic               erase,
`endif
    input  logic [ADDR_W-1:0]  pixel_index,
    output logic               pixel_hit,
    output logic [COUNT_W-1:0] drawn_count,
    output logic               busy,
    output logic               stroke_done
);

    localparam pixel_addr_t        c_last_addr = pixel_addr_t'(NUM_PIXELS - 1);
    localparam logic [K_W-1:0]     c_k_last    = K_W'(BRUSH_D - 1);
    localparam logic [COUNT_W-1:0] c_count_max = {COUNT_W{1'b1}};

    stroke_state_t      r_state, w_state_next;
    pixel_addr_t        r_clr_addr;
    logic [K_W-1:0]     r_kx, r_ky;
    logic [COORD_W-1:0] r_cx, r_cy, r_last_x, r_last_y;
    logic [COUNT_W-1:0] r_count;
    logic               r_mouse_l_q, r_stroke_done, r_erase_mode;

    logic [13:0]        w_px, w_py;
    pixel_addr_t        w_cell_addr, w_mem_addr;
    logic               w_cell_valid, w_cell_change, w_cell_last, w_clr_last;
    logic               w_start, w_release, w_erase_req;
    logic               w_mem_we, w_mem_wdata, w_mem_rdata, w_busy;

`ifdef STROKE_ERASE_EN
    assign w_erase_req = erase && !mouse_l;
`else
    assign w_erase_req = 1'b0;
`endif

    // Negative offsets wrap to large values, so one compare rejects both edges.
    assign w_px          = {2'b00, r_cx} + {{(14-K_W){1'b0}}, r_kx} - 14'(BRUSH_R);
    assign w_py          = {2'b00, r_cy} + {{(14-K_W){1'b0}}, r_ky} - 14'(BRUSH_R);
    assign w_cell_valid  = (w_px < 14'(SCREEN_W)) && (w_py < 14'(SCREEN_H));
    assign w_cell_addr   = pixel_addr(w_px, w_py);
    assign w_cell_change = w_cell_valid && (w_mem_rdata == r_erase_mode);
    assign w_cell_last   = (r_kx == c_k_last) && (r_ky == c_k_last);
    assign w_clr_last    = (r_clr_addr == c_last_addr);
    assign w_release     = r_mouse_l_q && !mouse_l;
    assign w_start       = (mouse_l || w_erase_req)
                         && (mouse_x < COORD_W'(SCREEN_W)) && (mouse_y < COORD_W'(SCREEN_H))
                         && ((mouse_x != r_last_x) || (mouse_y != r_last_y));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = CLEAR;
        end else begin
            case (r_state)
                IDLE:    if (w_start)     w_state_next = PAINT;
                PAINT:   if (w_cell_last) w_state_next = IDLE;
                CLEAR:   if (w_clr_last)  w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_wdata = 1'b0;
        w_mem_addr  = w_cell_addr;
        w_busy      = (r_state == CLEAR);
        case (r_state)
            PAINT: begin
                w_mem_we    = w_cell_change && !clear;
                w_mem_wdata = !r_erase_mode;
            end
            CLEAR: begin
                w_mem_addr  = r_clr_addr;
                w_mem_we    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_clr_addr    <= '0;
            r_kx          <= '0;
            r_ky          <= '0;
            r_cx          <= '0;
            r_cy          <= '0;
            r_last_x      <= '1;
            r_last_y      <= '1;
            r_count       <= '0;
            r_mouse_l_q   <= 1'b0;
            r_stroke_done <= 1'b0;
            r_erase_mode  <= 1'b0;
        end else begin
            r_mouse_l_q   <= mouse_l;
            r_stroke_done <= w_release && (r_state != CLEAR);
            if (clear) begin
                r_clr_addr <= '0;
                r_count    <= '0;
                r_kx       <= '0;
                r_ky       <= '0;
                r_last_x   <= '1;
                r_last_y   <= '1;
            end else begin
                case (r_state)
                    IDLE: if (w_start) begin
                        r_cx         <= mouse_x;
                        r_cy         <= mouse_y;
                        r_kx         <= '0;
                        r_ky         <= '0;
                        r_erase_mode <= !mouse_l;
                    end
                    PAINT: begin
                        if (w_cell_change) begin
                            if (r_erase_mode) begin
                                if (r_count != '0) r_count <= r_count - COUNT_W'(1);
                            end else if (r_count != c_count_max) begin
                                r_count <= r_count + COUNT_W'(1);
                            end
                        end
                        if (r_kx == c_k_last) begin
                            r_kx <= '0;
                            r_ky <= r_ky + K_W'(1);
                        end else begin
                            r_kx <= r_kx + K_W'(1);
                        end
                        if (w_cell_last) begin
                            r_last_x <= r_cx;
                            r_last_y <= r_cy;
                        end
                    end
                    CLEAR: r_clr_addr <= w_clr_last ? '0 : r_clr_addr + pixel_addr_t'(1);
                    default: ;
                endcase
                // A button release lets the next stroke repaint the same spot.
                if (w_release) begin
                    r_last_x <= '1;
                    r_last_y <= '1;
                end
            end
        end
    end

    stroke_bitmap u_bitmap (
        .clock      (clock),
        .reset_n    (reset_n),
        .fsm_we     (w_mem_we),
        .fsm_addr   (w_mem_addr),
        .fsm_wdata  (w_mem_wdata),
        .fsm_rdata  (w_mem_rdata),
        .disp_index (pixel_index),
        .disp_hit   (pixel_hit)
    );

    assign drawn_count = r_count;
    assign busy        = w_busy;
    assign stroke_done = r_stroke_done;

endmodule
`default_nettype wire
